// File: rtl/pcf8575_target.sv
// I2C target emulating a PCF8575 16-bit quasi-bidirectional expander: address match,
// paired-byte writes to the output latch, 16-bit input reads and an active-low change interrupt.
module pcf8575_target #(
  parameter logic [3:0]  ADDR_HI     = 4'b0100,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addr,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] port_in,
  output logic [15:0] port_out,
  output logic        int_n,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic [15:0]            pin_sync_q [SYNC_STAGES];
  logic                   scl_d_q, sda_d_q;
  logic                   scl_s, sda_s;
  logic [15:0]            pin_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign pin_s = pin_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d_q    <= 1'b1;
      sda_d_q    <= 1'b1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) pin_sync_q[i] <= '1;
    end else begin
      scl_sync_q    <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q    <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_d_q       <= scl_s;
      sda_d_q       <= sda_s;
      pin_sync_q[0] <= port_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) pin_sync_q[i] <= pin_sync_q[i-1];
    end
  end

  logic start_c, stop_c, scl_rise, scl_fall;
  assign start_c  = scl_s & sda_d_q & ~sda_s;
  assign stop_c   = scl_s & ~sda_d_q & sda_s;
  assign scl_rise = scl_s & ~scl_d_q;
  assign scl_fall = ~scl_s & scl_d_q;

  state_t      state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] rd_buf_q, rd_buf_d;
  logic [15:0] ref_q, ref_d;
  logic [15:0] port_q, port_d;
  logic        rw_q, rw_d;
  logic        pair_q, pair_d;
  logic        hi_q, hi_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        int_n_q, int_n_d;
  logic [7:0]  cur_byte;

  assign cur_byte = hi_q ? rd_buf_q[15:8] : rd_buf_q[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      shreg_q  <= '0;
      lo_q     <= '0;
      rd_buf_q <= '0;
      ref_q    <= pin_s;
      port_q   <= '1;
      rw_q     <= 1'b0;
      pair_q   <= 1'b0;
      hi_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      int_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      lo_q     <= lo_d;
      rd_buf_q <= rd_buf_d;
      ref_q    <= ref_d;
      port_q   <= port_d;
      rw_q     <= rw_d;
      pair_q   <= pair_d;
      hi_q     <= hi_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      int_n_q  <= int_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    lo_d     = lo_q;
    rd_buf_d = rd_buf_q;
    ref_d    = ref_q;
    port_d   = port_q;
    rw_d     = rw_q;
    pair_d   = pair_q;
    hi_d     = hi_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    int_n_d  = (pin_s == ref_q);

    // Bus conditions win over bit sampling in the same cycle
    if (start_c) begin
      state_d  = S_ADDR;
      bit_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise && bit_q != 4'd8) begin
            shreg_d = {shreg_q[6:0], sda_s};
            bit_d   = bit_q + 4'd1;
          end else if (scl_fall && bit_q == 4'd8) begin
            if (shreg_q[7:1] == {ADDR_HI, addr}) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shreg_q[0];
              state_d  = S_ADDR_ACK;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_d = '0;
            if (rw_q) begin
              rd_buf_d = pin_s;
              ref_d    = pin_s;
              hi_d     = 1'b0;
              sda_oe_d = ~pin_s[7];
              state_d  = S_RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              pair_d   = 1'b0;
              state_d  = S_WR_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise && bit_q != 4'd8) begin
            shreg_d = {shreg_q[6:0], sda_s};
            bit_d   = bit_q + 4'd1;
          end else if (scl_fall && bit_q == 4'd8) begin
            sda_oe_d = 1'b1;
            pair_d   = ~pair_q;
            if (!pair_q) begin
              lo_d = shreg_q;
            end else begin
              port_d = {shreg_q, lo_q};
              ref_d  = pin_s;
            end
            state_d = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            bit_d    = '0;
            state_d  = S_WR_BYTE;
          end
        end
        // bit_q counts rising edges already seen, so it indexes the next bit to present
        S_RD_BYTE: begin
          if (scl_rise && bit_q != 4'd8) begin
            bit_d = bit_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d = ~cur_byte[3'd7 - bit_q[2:0]];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              busy_d  = 1'b0;
              state_d = S_WAIT_STOP;
            end else begin
              bit_d   = '0;
              hi_d    = ~hi_q;
              state_d = S_RD_BYTE;
              if (hi_q) begin
                rd_buf_d = pin_s;
                ref_d    = pin_s;
              end
            end
          end
        end
        S_WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign port_out = port_q;
  assign int_n    = int_n_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pcf8575_target.sv
// Bench for pcf8575_target: bit-banged I2C initiator plus a transaction-level model of the
// expander (output latch, read snapshot, busy, interrupt) checked at every SCL high phase.
module tb_pcf8575_target;

  localparam int Q    = 10;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr_v;
  logic        m_scl, m_sda;
  logic        sda_bus;
  logic [15:0] port_in_v;
  logic        sda_oe;
  logic [15:0] port_out;
  logic        int_n;
  logic        busy;

  always #5 clk = ~clk;

  assign sda_bus = m_sda & ~sda_oe;

  pcf8575_target #(.ADDR_HI(4'b0100), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .addr(addr_v), .scl_i(m_scl), .sda_i(sda_bus),
    .sda_oe(sda_oe), .port_in(port_in_v), .port_out(port_out), .int_n(int_n), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of what the expander must present
  logic [15:0] m_port, m_snap, m_rd;
  logic [7:0]  m_lo;
  logic        m_pair, m_busy, m_hi, exp_oe;
  string       probe_name;
  event        probe_ev;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(probe_ev) begin
    check16({probe_name, " sda_oe"}, 16'(sda_oe), 16'(exp_oe));
    check16({probe_name, " port_out"}, port_out, m_port);
    check16({probe_name, " busy"}, 16'(busy), 16'(m_busy));
    check16({probe_name, " int_n"}, 16'(int_n), 16'(port_in_v == m_snap));
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic b, input logic eoe, output logic rb);
    m_sda = b;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    exp_oe = eoe;
    rb = sda_bus;
    ->probe_ev;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
    m_busy = 1'b0;
    exp_oe = 1'b0;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
    m_busy = 1'b0;
    exp_oe = 1'b0;
    probe_name = "stop";
    ->probe_ev;
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] d);
    logic rb;
    for (int i = 7; i >= 0; i--) sbit(d[i], 1'b0, rb);
  endtask

  task automatic addr_phase(input logic [7:0] ab, output logic acked);
    logic match;
    logic rb;
    match = (ab[7:1] == {4'b0100, addr_v});
    probe_name = "addr bit";
    send_bits(ab);
    m_busy = match;
    probe_name = "addr ack";
    sbit(1'b1, match, rb);
    acked = ~rb;
    if (match) begin
      m_pair = 1'b0;
      if (ab[0]) begin
        m_rd   = port_in_v;
        m_snap = port_in_v;
        m_hi   = 1'b0;
      end
    end
  endtask

  task automatic wr_data(input logic [7:0] d, output logic acked);
    logic rb;
    probe_name = "wr bit";
    send_bits(d);
    if (m_pair) begin
      m_port = {d, m_lo};
      m_snap = port_in_v;
    end else begin
      m_lo = d;
    end
    m_pair = ~m_pair;
    probe_name = "wr ack";
    sbit(1'b1, 1'b1, rb);
    acked = ~rb;
  endtask

  task automatic rd_data(input logic mack, output logic [7:0] got);
    logic [7:0] cur;
    logic rb;
    cur = m_hi ? m_rd[15:8] : m_rd[7:0];
    probe_name = "rd bit";
    for (int i = 7; i >= 0; i--) begin
      sbit(1'b1, ~cur[i], rb);
      got[i] = rb;
    end
    if (!mack) begin
      m_busy = 1'b0;
    end else if (m_hi) begin
      m_rd   = port_in_v;
      m_snap = port_in_v;
    end
    probe_name = "rd mack";
    sbit(~mack, 1'b0, rb);
    m_hi = ~m_hi;
  endtask

  task automatic set_pins(input logic [15:0] v);
    port_in_v = v;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       found;
    logic [7:0] b0, b1;
    logic       rb;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; addr_v = 3'd0; port_in_v = 16'hFFFF;
    m_port = 16'hFFFF; m_snap = 16'hFFFF; m_rd = '0; m_lo = '0;
    m_pair = 1'b0; m_busy = 1'b0; m_hi = 1'b0; exp_oe = 1'b0; probe_name = "";
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check16("reset sda_oe", 16'(sda_oe), 16'h0);
    check16("reset port_out", port_out, 16'hFFFF);
    check16("reset int_n", 16'(int_n), 16'h1);
    check16("reset busy", 16'(busy), 16'h0);

    // Input change raises the interrupt within SYNC+2 clocks
    port_in_v = 16'hFFFE;
    found = 1'b0;
    for (int k = 0; k < SYNC + 2; k++) begin
      @(posedge clk);
      #1;
      if (!int_n) begin
        found = 1'b1;
        break;
      end
    end
    check16("int assert latency", 16'(found), 16'h1);
    repeat (10) @(posedge clk);
    #1;
    i2c_start();
    addr_phase(8'h41, ack);
    check16("rd FFFE addr ack", 16'(ack), 16'h1);
    check16("int cleared by read", 16'(int_n), 16'h1);
    rd_data(1'b0, b0);
    check16("rd FFFE byte", 16'(b0), 16'h00FE);
    i2c_stop();

    // Incomplete pair leaves the latch alone
    i2c_start();
    addr_phase(8'h40, ack);
    wr_data(8'h12, ack);
    i2c_stop();
    check16("partial pair port_out", port_out, 16'hFFFF);

    // Repeated START in the middle of a data byte
    i2c_start();
    addr_phase(8'h40, ack);
    probe_name = "partial bit";
    for (int i = 0; i < 4; i++) sbit(i[0], 1'b0, rb);
    i2c_start();
    addr_phase(8'h40, ack);
    wr_data(8'h34, ack);
    wr_data(8'h56, ack);
    i2c_stop();
    check16("rep start port_out", port_out, 16'h5634);

    i2c_start();
    addr_phase(8'h40, ack);
    check16("wr addr ack", 16'(ack), 16'h1);
    wr_data(8'h5A, ack);
    check16("wr lo ack", 16'(ack), 16'h1);
    wr_data(8'hC3, ack);
    check16("wr hi ack", 16'(ack), 16'h1);
    check16("wr port_out", port_out, 16'hC35A);
    i2c_stop();
    check16("busy after stop", 16'(busy), 16'h0);

    set_pins(16'hBEEF);
    i2c_start();
    addr_phase(8'h41, ack);
    rd_data(1'b1, b0);
    rd_data(1'b0, b1);
    check16("rd BEEF lo", 16'(b0), 16'h00EF);
    check16("rd BEEF hi", 16'(b1), 16'h00BE);
    check16("sda_oe after nack", 16'(sda_oe), 16'h0);
    i2c_stop();
    check16("int_n after read", 16'(int_n), 16'h1);

    i2c_start();
    addr_phase(8'h42, ack);
    check16("mismatch ack", 16'(ack), 16'h0);
    check16("mismatch busy", 16'(busy), 16'h0);
    i2c_stop();
    check16("mismatch port_out", port_out, 16'hC35A);

    // Reset while the target is driving a read bit low
    set_pins(16'h1234);
    i2c_start();
    addr_phase(8'h41, ack);
    check16("pre-reset sda_oe", 16'(sda_oe), 16'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check16("mid reset sda_oe", 16'(sda_oe), 16'h0);
    check16("mid reset port_out", port_out, 16'hFFFF);
    check16("mid reset busy", 16'(busy), 16'h0);
    m_port = 16'hFFFF; m_busy = 1'b0; m_snap = 16'h1234; exp_oe = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    i2c_start();
    addr_phase(8'h40, ack);
    check16("post reset ack", 16'(ack), 16'h1);
    i2c_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
